sipo_rx: RTL and testbench

Serial-in parallel-out receiver. It is the far end of the shift link driven by our parallel-in serial-out transmitter. It samples one bit per clock while `shift` is high and assembles WIDTH-bit words. Each completed word is presented on a valid/ready holding register, with overrun and framing-error reporting. It sits between the serial link and the word-consuming logic.

---
 rtl/serial_link_pkg.sv | 11 +
 rtl/sipo_rx_if.sv | 11 +
 rtl/sipo_shift_reg.sv | 26 ++
 rtl/sipo_rx.sv | 84 ++++++++
 tb/tb_sipo_rx.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the serial shift link (transmitter and receiver).
package serial_link_pkg;
  localparam int DEFAULT_WIDTH   = 4;
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } link_state_t;
endpackage

// File: rtl/sipo_rx_if.sv
// Word-side valid/ready handshake between the receiver and the word-consuming logic.
interface sipo_rx_if #(
  parameter int WIDTH = serial_link_pkg::DEFAULT_WIDTH
) ();
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;

  modport master (output data_out, output out_valid, input out_ready);
  modport slave  (input data_out, input out_valid, output out_ready);
endinterface

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial shift register; nxt is the word including the bit being sampled now.
module sipo_shift_reg
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] sr_p0;

  // A new word needs no flush: WIDTH shifts push every stale bit out.
  always_comb begin
    if (MSB_FIRST) nxt = {sr_p0[WIDTH-2:0], din};
    else           nxt = {din, sr_p0[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (clear)   sr_p0 <= '0;
    else if (en) sr_p0 <= nxt;
  end
endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words and holds them on a valid/ready register.
module sipo_rx
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          shift,
  input  logic          data_in,
  sipo_rx_if.master     wif,
  output logic          overrun,
  output logic          frame_err,
  output logic [CW-1:0] bit_count
);
  link_state_t      state;
  logic [WIDTH-1:0] word_nxt;
  logic [WIDTH-1:0] data_p0;
  logic             vld_p0;
  logic [CW-1:0]    cnt_p0;
  logic             xfer;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk   (clk),
    .clear (clear),
    .en    (shift),
    .din   (data_in),
    .nxt   (word_nxt)
  );

  assign xfer          = vld_p0 && wif.out_ready;
  assign wif.data_out  = data_p0;
  assign wif.out_valid = vld_p0;
  assign bit_count     = cnt_p0;

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      cnt_p0    <= '0;
      data_p0   <= '0;
      vld_p0    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // A transfer empties the holder unless a completing word refills it below.
      if (xfer) vld_p0 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (shift) begin
            cnt_p0 <= CW'(1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift) begin
            if (cnt_p0 == CW'(WIDTH - 1)) begin
              cnt_p0 <= '0;
              state  <= IDLE;
              if (!vld_p0 || wif.out_ready) begin
                data_p0 <= word_nxt;
                vld_p0  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              cnt_p0 <= cnt_p0 + CW'(1);
            end
          end else begin
            frame_err <= 1'b1;
            cnt_p0    <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: two instances (MSB-first and LSB-first) share one stimulus stream.
module tb_sipo_rx;
  import serial_link_pkg::*;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic clear, shift, data_in;
  logic ovr_a, fe_a, ovr_b, fe_b;
  logic [CW-1:0] bc_a, bc_b;

  always #5 clk = ~clk;

  sipo_rx_if #(.WIDTH(W)) wa ();
  sipo_rx_if #(.WIDTH(W)) wb ();

  sipo_rx #(.WIDTH(W), .MSB_FIRST(ORDER_MSB_FIRST)) dut_a (
    .clk(clk), .clear(clear), .shift(shift), .data_in(data_in), .wif(wa),
    .overrun(ovr_a), .frame_err(fe_a), .bit_count(bc_a)
  );

  sipo_rx #(.WIDTH(W), .MSB_FIRST(ORDER_LSB_FIRST)) dut_b (
    .clk(clk), .clear(clear), .shift(shift), .data_in(data_in), .wif(wb),
    .overrun(ovr_b), .frame_err(fe_b), .bit_count(bc_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: bits of the word in progress, plus the holder of each instance.
  bit         bq[$];
  logic       m_vld [2];
  logic [W-1:0] m_dat [2];
  logic       m_ovr [2];
  logic       m_fe;

  function automatic logic [W-1:0] compose(bit msb);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) r[W-1-i] = bq[i];
      else     r[i]     = bq[i];
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(bit c, bit s, bit d, bit r);
    logic [W-1:0] w [2];
    if (c) begin
      bq.delete();
      m_fe = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_vld[k] = 1'b0; m_dat[k] = '0; m_ovr[k] = 1'b0;
      end
      return;
    end
    m_fe = 1'b0;
    if (s) begin
      bq.push_back(d);
      if (bq.size() == W) begin
        w[0] = compose(1'b1);
        w[1] = compose(1'b0);
        for (int k = 0; k < 2; k++) begin
          if (!m_vld[k] || r) begin
            m_dat[k] = w[k];
            m_vld[k] = 1'b1;
          end else begin
            m_ovr[k] = 1'b1;
          end
        end
        bq.delete();
        return;
      end
    end else if (bq.size() > 0) begin
      m_fe = 1'b1;
      bq.delete();
    end
    for (int k = 0; k < 2; k++)
      if (m_vld[k] && r) m_vld[k] = 1'b0;
  endtask

  task automatic compare_all();
    chk("a.data_out",  32'(wa.data_out),  32'(m_dat[0]));
    chk("a.out_valid", 32'(wa.out_valid), 32'(m_vld[0]));
    chk("a.overrun",   32'(ovr_a),        32'(m_ovr[0]));
    chk("a.frame_err", 32'(fe_a),         32'(m_fe));
    chk("a.bit_count", 32'(bc_a),         32'(bq.size()));
    chk("b.data_out",  32'(wb.data_out),  32'(m_dat[1]));
    chk("b.out_valid", 32'(wb.out_valid), 32'(m_vld[1]));
    chk("b.overrun",   32'(ovr_b),        32'(m_ovr[1]));
    chk("b.frame_err", 32'(fe_b),         32'(m_fe));
    chk("b.bit_count", 32'(bc_b),         32'(bq.size()));
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(bit c, bit s, bit d, bit r);
    clear = c; shift = s; data_in = d;
    wa.out_ready = r; wb.out_ready = r;
    model_edge(c, s, d, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(logic [W-1:0] bits_first_at_msb, bit r);
    for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, bits_first_at_msb[i], r);
  endtask

  initial begin
    clear = 1'b1; shift = 1'b0; data_in = 1'b0;
    wa.out_ready = 1'b0; wb.out_ready = 1'b0;

    // Reset state and a single word with the consumer ready
    step(1, 0, 0, 1);
    chk("lit.reset_valid", 32'(wa.out_valid), 32'd0);
    chk("lit.reset_bc",    32'(bc_a),         32'd0);
    send(4'b1110, 1'b1);
    chk("lit.t1_a", 32'(wa.data_out), 32'h0000000e);
    chk("lit.t1_b", 32'(wb.data_out), 32'h00000007);
    chk("lit.t1_valid", 32'(wa.out_valid), 32'd1);
    chk("lit.t1_bc", 32'(bc_a), 32'd0);
    step(0, 0, 0, 1);
    chk("lit.t1_consumed", 32'(wa.out_valid), 32'd0);

    // Back-to-back words with no gap
    send(4'b0110, 1'b1);
    chk("lit.t2_w1", 32'(wa.data_out), 32'h00000006);
    send(4'b1111, 1'b1);
    chk("lit.t2_w2", 32'(wa.data_out), 32'h0000000f);
    chk("lit.t2_valid", 32'(wa.out_valid), 32'd1);
    step(0, 0, 0, 1);

    // Overrun with the consumer stalled
    send(4'b1110, 1'b0);
    send(4'b0110, 1'b0);
    chk("lit.t3_kept", 32'(wa.data_out), 32'h0000000e);
    chk("lit.t3_ovr",  32'(ovr_a),       32'd1);
    step(0, 0, 0, 1);
    chk("lit.t3_drain", 32'(wa.out_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("lit.t3_sticky", 32'(ovr_a), 32'd1);

    // Completion on the same edge as a transfer
    step(1, 0, 0, 0);
    send(4'b1110, 1'b0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    chk("lit.t4_data",  32'(wa.data_out),  32'h00000005);
    chk("lit.t4_valid", 32'(wa.out_valid), 32'd1);
    chk("lit.t4_ovr",   32'(ovr_a),        32'd0);
    step(0, 0, 0, 1);

    // Framing error while a word is held
    send(4'b1010, 1'b0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("lit.t5_fe",    32'(fe_a),         32'd1);
    chk("lit.t5_bc",    32'(bc_a),         32'd0);
    chk("lit.t5_valid", 32'(wa.out_valid), 32'd1);
    step(0, 0, 0, 1);
    chk("lit.t5_fe_gone", 32'(fe_a), 32'd0);
    send(4'b0011, 1'b1);
    chk("lit.t5_next", 32'(wa.data_out), 32'h00000003);

    // Reset in the middle of a word
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("lit.t6_data", 32'(wa.data_out), 32'd0);
    chk("lit.t6_fe",   32'(fe_a),        32'd0);
    chk("lit.t6_bc",   32'(bc_a),        32'd0);
    send(4'b1001, 1'b1);
    chk("lit.t6_a", 32'(wa.data_out), 32'h00000009);
    send(4'b1000, 1'b1);
    chk("lit.t6_b_lsb", 32'(wb.data_out), 32'h00000001);
    chk("lit.t6_a_msb", 32'(wa.data_out), 32'h00000008);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
